pong_engine_mp: RTL and testbench

- Parametrised second-generation Pong game engine.
- Owns ball/paddle kinematics, scoring, serve delay and win detection, and sequences them with a game state machine.
- Advances once per frame on a `frame_tick` pulse from the VGA timing block.
- Publishes coordinates and scores to the separate renderer. It does no pixel drawing itself, unlike the first-generation combined display/game block.

---
 rtl/pong_engine_mp.sv | 232 +++++++++++++++++++++++
 tb/tb_pong_engine_mp.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pong_engine_mp.sv
// Frame-stepped Pong game engine: paddle/ball kinematics, scoring, serve delay
// and win detection, publishing registered coordinates for a separate renderer.
module pong_engine_mp #(
    parameter int COORD_W      = 11,
    parameter int FIELD_TOP    = 165,
    parameter int FIELD_BOT    = 434,
    parameter int FIELD_LEFT   = 215,
    parameter int FIELD_RIGHT  = 584,
    parameter int BALL_SIZE    = 20,
    parameter int PADDLE_LEN   = 48,
    parameter int BALL_STEP    = 5,
    parameter int PADDLE_STEP  = 5,
    parameter int SCORE_W      = 6,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               play,
    input  logic               p1_up,
    input  logic               p1_dn,
    input  logic               p2_up,
    input  logic               p2_dn,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic [COORD_W-1:0] p1_y,
    output logic [COORD_W-1:0] p2_y,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [2:0]         state,
    output logic [1:0]         winner
);

    localparam int BX0   = (FIELD_LEFT + FIELD_RIGHT + 1 - BALL_SIZE) / 2;
    localparam int BY0   = (FIELD_TOP + FIELD_BOT + 1 - BALL_SIZE) / 2;
    localparam int PY0   = (FIELD_TOP + FIELD_BOT + 1 - PADDLE_LEN) / 2;
    localparam int PYMAX = FIELD_BOT - PADDLE_LEN + 1;
    localparam int BXMAX = FIELD_RIGHT - BALL_SIZE + 1;
    localparam int BYMAX = FIELD_BOT - BALL_SIZE + 1;
    localparam int SW    = COORD_W + 2;
    localparam int CNT_W = (SERVE_FRAMES > 2) ? $clog2(SERVE_FRAMES) : 1;

    typedef logic signed [SW-1:0] sc_t;

    localparam sc_t TOP_S    = sc_t'(FIELD_TOP);
    localparam sc_t LEFT_S   = sc_t'(FIELD_LEFT);
    localparam sc_t PYMAX_S  = sc_t'(PYMAX);
    localparam sc_t BXMAX_S  = sc_t'(BXMAX);
    localparam sc_t BYMAX_S  = sc_t'(BYMAX);
    localparam sc_t BSTEP_S  = sc_t'(BALL_STEP);
    localparam sc_t PSTEP_S  = sc_t'(PADDLE_STEP);
    localparam sc_t PLEN_M1  = sc_t'(PADDLE_LEN - 1);
    localparam sc_t BSIZE_M1 = sc_t'(BALL_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SERVE    = 3'd1,
        S_PLAY     = 3'd2,
        S_POINT    = 3'd3,
        S_GAMEOVER = 3'd4
    } state_t;

    state_t             state_q;
    logic               vx_neg;
    logic               vy_neg;
    logic               p2_scored;
    logic [CNT_W-1:0]   serve_cnt;

    sc_t                nx;
    sc_t                ny;
    logic [COORD_W-1:0] bx_nxt;
    logic [COORD_W-1:0] by_nxt;
    logic               vx_neg_nxt;
    logic               vy_neg_nxt;
    logic               miss;
    logic [COORD_W-1:0] p1_nxt;
    logic [COORD_W-1:0] p2_nxt;
    logic [SCORE_W-1:0] s1_inc;
    logic [SCORE_W-1:0] s2_inc;

    function automatic sc_t ext(input logic [COORD_W-1:0] v);
        return sc_t'({2'b00, v});
    endfunction

    function automatic logic [COORD_W-1:0] move_paddle(input logic [COORD_W-1:0] y,
                                                      input logic up, input logic dn);
        sc_t t;
        t = ext(y);
        if (up && !dn) begin
            t = t - PSTEP_S;
            if (t < TOP_S) t = TOP_S;
        end else if (dn && !up) begin
            t = t + PSTEP_S;
            if (t > PYMAX_S) t = PYMAX_S;
        end
        return t[COORD_W-1:0];
    endfunction

    function automatic logic overlaps(input logic [COORD_W-1:0] by, input logic [COORD_W-1:0] py);
        return (ext(by) <= ext(py) + PLEN_M1) && (ext(py) <= ext(by) + BSIZE_M1);
    endfunction

    // Candidate next-frame kinematics, all based on the pre-tick positions.
    always_comb begin
        p1_nxt = move_paddle(p1_y, p1_up, p1_dn);
        p2_nxt = move_paddle(p2_y, p2_up, p2_dn);

        ny         = vy_neg ? ext(ball_y) - BSTEP_S : ext(ball_y) + BSTEP_S;
        by_nxt     = ny[COORD_W-1:0];
        vy_neg_nxt = vy_neg;
        if (ny <= TOP_S) begin
            by_nxt     = TOP_S[COORD_W-1:0];
            vy_neg_nxt = 1'b0;
        end else if (ny >= BYMAX_S) begin
            by_nxt     = BYMAX_S[COORD_W-1:0];
            vy_neg_nxt = 1'b1;
        end

        nx         = vx_neg ? ext(ball_x) - BSTEP_S : ext(ball_x) + BSTEP_S;
        bx_nxt     = nx[COORD_W-1:0];
        vx_neg_nxt = vx_neg;
        miss       = 1'b0;
        if (vx_neg && nx <= LEFT_S) begin
            if (overlaps(ball_y, p1_y)) begin
                bx_nxt     = LEFT_S[COORD_W-1:0];
                vx_neg_nxt = 1'b0;
            end else begin
                bx_nxt = ball_x;
                miss   = 1'b1;
            end
        end else if (!vx_neg && nx >= BXMAX_S) begin
            if (overlaps(ball_y, p2_y)) begin
                bx_nxt     = BXMAX_S[COORD_W-1:0];
                vx_neg_nxt = 1'b1;
            end else begin
                bx_nxt = ball_x;
                miss   = 1'b1;
            end
        end

        s1_inc = score_p1 + 1'b1;
        s2_inc = score_p2 + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ball_x    <= COORD_W'(BX0);
            ball_y    <= COORD_W'(BY0);
            p1_y      <= COORD_W'(PY0);
            p2_y      <= COORD_W'(PY0);
            score_p1  <= '0;
            score_p2  <= '0;
            winner    <= 2'b00;
            vx_neg    <= 1'b0;
            vy_neg    <= 1'b0;
            p2_scored <= 1'b0;
            serve_cnt <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (play) begin
                        score_p1  <= '0;
                        score_p2  <= '0;
                        winner    <= 2'b00;
                        serve_cnt <= '0;
                        state_q   <= S_SERVE;
                    end
                end
                S_SERVE: begin
                    if (play && frame_tick) begin
                        p1_y <= p1_nxt;
                        p2_y <= p2_nxt;
                        if (serve_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
                            serve_cnt <= '0;
                            state_q   <= S_PLAY;
                        end else begin
                            serve_cnt <= serve_cnt + 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (play && frame_tick) begin
                        p1_y   <= p1_nxt;
                        p2_y   <= p2_nxt;
                        ball_y <= by_nxt;
                        vy_neg <= vy_neg_nxt;
                        ball_x <= bx_nxt;
                        if (miss) begin
                            // A miss while travelling left means P1 conceded.
                            p2_scored <= vx_neg;
                            state_q   <= S_POINT;
                        end else begin
                            vx_neg <= vx_neg_nxt;
                        end
                    end
                end
                S_POINT: begin
                    ball_x    <= COORD_W'(BX0);
                    ball_y    <= COORD_W'(BY0);
                    vx_neg    <= p2_scored;
                    serve_cnt <= '0;
                    if (p2_scored) begin
                        score_p2 <= s2_inc;
                        if (s2_inc == SCORE_W'(WIN_SCORE)) begin
                            winner  <= 2'b10;
                            state_q <= S_GAMEOVER;
                        end else begin
                            state_q <= S_SERVE;
                        end
                    end else begin
                        score_p1 <= s1_inc;
                        if (s1_inc == SCORE_W'(WIN_SCORE)) begin
                            winner  <= 2'b01;
                            state_q <= S_GAMEOVER;
                        end else begin
                            state_q <= S_SERVE;
                        end
                    end
                end
                S_GAMEOVER: begin
                    if (!play) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pong_engine_mp.sv
// Directed bench for pong_engine_mp: table of frame segments with hand-computed
// positions and scores, plus rally loops for the scoring/game-over corners.
module tb_pong_engine_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        play;
    logic        p1_up, p1_dn, p2_up, p2_dn;
    logic [10:0] ball_x, ball_y, p1_y, p2_y;
    logic [5:0]  score_p1, score_p2;
    logic [2:0]  state;
    logic [1:0]  winner;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int    ticks;
        bit    pl, u1, d1, u2, d2;
        int    st, bx, by, py1, py2, s1, s2, win;
        string name;
    } vec_t;

    vec_t phase1[$];
    vec_t phase2[$];

    always #5 clk = ~clk;

    pong_engine_mp dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .play       (play),
        .p1_up      (p1_up),
        .p1_dn      (p1_dn),
        .p2_up      (p2_up),
        .p2_dn      (p2_dn),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .p1_y       (p1_y),
        .p2_y       (p2_y),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .state      (state),
        .winner     (winner)
    );

    // Each frame is a one-cycle tick followed by three quiet cycles so single-cycle
    // POINT and any-cycle IDLE/GAMEOVER transitions settle before sampling.
    task automatic applyStimulus(input int ticks, input bit pl, input bit u1, input bit d1,
                                 input bit u2, input bit d2);
        play  = pl;
        p1_up = u1;
        p1_dn = d1;
        p2_up = u2;
        p2_dn = d2;
        for (int i = 0; i < ticks; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic checkField(input string name, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s.%s: got %0d, expected %0d", name, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input int st, input int bx, input int by,
                               input int py1, input int py2, input int s1, input int s2,
                               input int win);
        checkField(name, "state",    {29'd0, state},    st);
        checkField(name, "ball_x",   {21'd0, ball_x},   bx);
        checkField(name, "ball_y",   {21'd0, ball_y},   by);
        checkField(name, "p1_y",     {21'd0, p1_y},     py1);
        checkField(name, "p2_y",     {21'd0, p2_y},     py2);
        checkField(name, "score_p1", {26'd0, score_p1}, s1);
        checkField(name, "score_p2", {26'd0, score_p2}, s2);
        checkField(name, "winner",   {30'd0, winner},   win);
    endtask

    task automatic runTable(input vec_t q[$]);
        foreach (q[i]) begin
            applyStimulus(q[i].ticks, q[i].pl, q[i].u1, q[i].d1, q[i].u2, q[i].d2);
            checkOutput(q[i].name, q[i].st, q[i].bx, q[i].by, q[i].py1, q[i].py2,
                        q[i].s1, q[i].s2, q[i].win);
        end
    endtask

    initial begin
        // ticks pl u1 d1 u2 d2 | state bx by p1 p2 s1 s2 win | name
        phase1.push_back('{3,  0,1,0,0,1, 0, 390,290, 276,276, 0,0,0, "idle_frozen"});
        phase1.push_back('{0,  1,0,0,0,0, 1, 390,290, 276,276, 0,0,0, "start_serve"});
        phase1.push_back('{22, 1,1,0,0,1, 1, 390,290, 166,386, 0,0,0, "paddles_move"});
        phase1.push_back('{1,  1,1,0,0,1, 1, 390,290, 165,387, 0,0,0, "paddle_clamp"});
        phase1.push_back('{2,  1,1,0,0,1, 1, 390,290, 165,387, 0,0,0, "paddle_hold_lim"});
        phase1.push_back('{3,  1,1,1,1,1, 1, 390,290, 165,387, 0,0,0, "both_buttons"});
        phase1.push_back('{10, 0,0,1,1,0, 1, 390,290, 165,387, 0,0,0, "serve_paused"});
        phase1.push_back('{31, 1,0,0,0,0, 1, 390,290, 165,387, 0,0,0, "serve_tick59"});
        phase1.push_back('{1,  1,0,0,0,0, 2, 390,290, 165,387, 0,0,0, "serve_to_play"});
        phase1.push_back('{1,  1,0,0,0,0, 2, 395,295, 165,387, 0,0,0, "first_move"});
        phase1.push_back('{24, 1,0,0,0,0, 2, 515,415, 165,387, 0,0,0, "bottom_wall"});
        phase1.push_back('{1,  1,0,0,0,0, 2, 520,410, 165,387, 0,0,0, "after_bottom"});
        phase1.push_back('{8,  1,0,0,0,0, 2, 560,370, 165,387, 0,0,0, "near_p2"});
        phase1.push_back('{1,  1,0,0,0,0, 2, 565,365, 165,387, 0,0,0, "p2_edge_hit"});
        phase1.push_back('{39, 1,0,0,0,0, 2, 370,170, 165,387, 0,0,0, "near_top"});
        phase1.push_back('{1,  1,0,0,0,0, 2, 365,165, 165,387, 0,0,0, "top_wall"});
        phase1.push_back('{1,  1,0,0,0,0, 2, 360,170, 165,387, 0,0,0, "after_top"});
        phase1.push_back('{20, 1,0,1,0,0, 2, 260,270, 265,387, 0,0,0, "p1_track"});
        phase1.push_back('{8,  1,0,0,0,0, 2, 220,310, 265,387, 0,0,0, "near_p1"});
        phase1.push_back('{1,  1,0,0,0,0, 2, 215,315, 265,387, 0,0,0, "p1_edge_hit"});
        phase1.push_back('{1,  1,0,0,0,0, 2, 220,320, 265,387, 0,0,0, "after_p1_hit"});
        phase1.push_back('{19, 1,0,0,0,0, 2, 315,415, 265,387, 0,0,0, "bottom_wall2"});
        phase1.push_back('{49, 1,0,0,0,0, 2, 560,170, 265,387, 0,0,0, "corner_approach"});
        phase1.push_back('{1,  1,0,0,0,0, 1, 390,290, 265,387, 1,0,0, "p2_miss_point"});

        phase2.push_back('{3,  1,0,1,0,1, 4, 390,290, 265,287, 7,0,1, "gameover_frozen"});
        phase2.push_back('{0,  0,0,0,0,0, 0, 390,290, 265,287, 7,0,1, "gameover_idle"});
        phase2.push_back('{0,  1,0,0,0,0, 1, 390,290, 265,287, 0,0,0, "restart"});
        phase2.push_back('{20, 1,1,0,0,1, 1, 390,290, 165,387, 0,0,0, "reposition"});
        phase2.push_back('{40, 1,0,0,0,0, 2, 390,290, 165,387, 0,0,0, "play_game2"});
        phase2.push_back('{35, 1,0,0,0,0, 2, 565,365, 165,387, 0,0,0, "p2_hit_g2"});
        phase2.push_back('{40, 1,0,0,0,0, 2, 365,165, 165,387, 0,0,0, "top_g2"});
        phase2.push_back('{29, 1,0,0,0,0, 2, 220,310, 165,387, 0,0,0, "near_p1_g2"});
        phase2.push_back('{1,  1,0,0,0,0, 1, 390,290, 165,387, 0,1,0, "p1_miss_point"});
        phase2.push_back('{60, 1,0,0,0,0, 2, 390,290, 165,387, 0,1,0, "serve_left"});
        phase2.push_back('{1,  1,0,0,0,0, 2, 385,295, 165,387, 0,1,0, "vx_toward_p1"});
        phase2.push_back('{10, 0,1,0,0,1, 2, 385,295, 165,387, 0,1,0, "play_paused"});

        rst        = 1'b0;
        frame_tick = 1'b0;
        play       = 1'b0;
        p1_up      = 1'b0;
        p1_dn      = 1'b0;
        p2_up      = 1'b0;
        p2_dn      = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset", 0, 390, 290, 276, 276, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);

        runTable(phase1);

        // Rallies 2..7: P2 parked at 287 misses both serve trajectories, so P1
        // scores on the 35th play frame each time; the seventh point ends the game.
        for (int r = 2; r <= 7; r++) begin
            applyStimulus(20, 1'b1, 1'b0, 1'b0, (r == 2), 1'b0);
            applyStimulus(40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("rally%0d_start", r), 2, 390, 290, 265, 287, r - 1, 0, 0);
            applyStimulus(34, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("rally%0d_edge", r), 2, 560, (r % 2 == 0) ? 370 : 210,
                        265, 287, r - 1, 0, 0);
            applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("rally%0d_point", r), (r < 7) ? 1 : 4, 390, 290, 265, 287,
                        r, 0, (r < 7) ? 0 : 1);
        end

        runTable(phase2);

        // Synchronous reset asserted mid-PLAY takes effect on the very next edge.
        play = 1'b1;
        rst  = 1'b0;
        @(negedge clk);
        checkOutput("reset_mid_play", 0, 390, 290, 276, 276, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        checkField("after_reset", "state", {29'd0, state}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
